// File: rtl/daq_event_buffer_if.sv
// ---------------------------------------------------------------------------
// daq_event_buffer_if
//   Groups the sample input bus, the trigger/control inputs and the read-side
//   data and header outputs of daq_event_buffer into one bundle.
//
//   Configuration macro: PARITY_EN adds the per-channel parity error vector perr.
//
//   Signals
//     gin        NGRP*NCH*SW  group g, channel c at bits [(g*NCH+c)*SW +: SW]
//     gin_vld    1            one-cycle strobe, new sample on gin
//     trig       1            one-cycle trigger
//     samp_max   7            samples per event minus 1
//     rd_ena     NCH          per-channel data read enable
//     dout       NCH*SW       channel c at bits [c*SW +: SW]
//     hdr_rd_en  1            header read enable
//     hdr_out    32           header word
//     rdy        1            header FIFO not empty
//     drop_cnt   16           dropped events, saturating
//     seq_err    1            sticky sample sequencing error
//     perr       NCH          (PARITY_EN only) parity failure of the word just read
//
//   Modports: master drives the inputs (environment), slave is the buffer.
// ---------------------------------------------------------------------------
interface daq_event_buffer_if #(
    parameter int NCH  = 16,
    parameter int SW   = 12,
    parameter int NGRP = 6
);
    logic [NGRP*NCH*SW-1:0] gin;
    logic                   gin_vld;
    logic                   trig;
    logic [6:0]             samp_max;
    logic [NCH-1:0]         rd_ena;
    logic [NCH*SW-1:0]      dout;
    logic                   hdr_rd_en;
    logic [31:0]            hdr_out;
    logic                   rdy;
    logic [15:0]            drop_cnt;
    logic                   seq_err;
`ifdef PARITY_EN
    logic [NCH-1:0]         perr;
`endif

    modport master (
        output gin, gin_vld, trig, samp_max, rd_ena, hdr_rd_en,
        input  dout, hdr_out, rdy, drop_cnt, seq_err
`ifdef PARITY_EN
        , input perr
`endif
    );

    modport slave (
        input  gin, gin_vld, trig, samp_max, rd_ena, hdr_rd_en,
        output dout, hdr_out, rdy, drop_cnt, seq_err
`ifdef PARITY_EN
        , output perr
`endif
    );
endinterface

// File: rtl/daq_event_buffer.sv
// ---------------------------------------------------------------------------
// daq_event_buffer
//   Captures a triggered window of samp_max+1 samples from NGRP time-multiplexed
//   ADC groups into NCH per-channel data FIFOs and writes one 32-bit header word
//   per accepted event. Triggers arriving during a capture are queued; events
//   that do not fit are dropped whole and counted.
//
//   Configuration macro: PARITY_EN -- store an even-parity bit with every data
//   word and report failures on bus.perr, registered together with dout.
//
//   Ports
//     clk    in  clock
//     rst_n  in  asynchronous active-low reset, discards all state and FIFO data
//     bus    slave modport of daq_event_buffer_if (sample bus, trigger,
//            data/header read ports, status)
//
//   Header word: {drop_flag, pend_sat, pend_after_launch[3:0], 2'b00, trig_cnt[23:0]}
// ---------------------------------------------------------------------------
module daq_event_buffer #(
    parameter int NCH       = 16,
    parameter int SW        = 12,
    parameter int NGRP      = 6,
    parameter int DEPTH     = 1024,
    parameter int HDR_DEPTH = 64
) (
    input logic               clk,
    input logic               rst_n,
    daq_event_buffer_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int HAW = $clog2(HDR_DEPTH);
    localparam int GW  = (NGRP > 1) ? $clog2(NGRP) : 1;
`ifdef PARITY_EN
    localparam int WW  = SW + 1;
`else
    localparam int WW  = SW;
`endif

    typedef enum logic [0:0] {IDLE, CAPTURE} state_t;

    state_t                 state;
    logic [23:0]            trig_cnt;
    logic [3:0]             pend;
    logic                   pend_sat;
    logic                   drop_flag;
    logic [15:0]            drop_cnt;
    logic                   seq_err;
    logic [6:0]             samp_max_l;
    logic [6:0]             samp_cnt;
    logic                   last_taken;
    logic                   wr_act;
    logic [GW-1:0]          sel;
    logic [NGRP*NCH*SW-1:0] hold;

    logic [WW-1:0]          data_mem [NCH][DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr [NCH];
    logic [AW:0]            occ [NCH];
    logic [SW-1:0]          dout_r [NCH];
    logic [NCH*SW-1:0]      dout_flat;
    logic [NCH-1:0]         rd_do;
    logic [WW-1:0]          wr_word [NCH];

    logic [31:0]            hdr_mem [HDR_DEPTH];
    logic [HAW-1:0]         hdr_wp;
    logic [HAW-1:0]         hdr_rp;
    logic [HAW:0]           hdr_cnt;
    logic [31:0]            hdr_out_r;
    logic                   hdr_rd;

    logic                   last_grp;
    logic                   busy;
    logic                   launch;
    logic                   admit;
    logic                   drop;
    logic                   take;
    logic [3:0]             pend_nxt;
    logic [AW:0]            max_occ;
    logic [31:0]            free_words;
    logic [31:0]            need_words;
    logic [31:0]            hdr_word;

    // The last group write of a sample frees the holding register, so a new
    // sample may land on that cycle without disturbing the write in flight.
    assign last_grp = (sel == GW'(NGRP - 1));
    assign busy     = wr_act && !last_grp;

    // All channels are written together, so the fullest one bounds free space.
    always_comb begin
        max_occ = '0;
        for (int c = 0; c < NCH; c++) begin
            if (occ[c] > max_occ) max_occ = occ[c];
        end
    end

    assign launch     = (state == IDLE) && bus.gin_vld && ((pend != 4'd0) || bus.trig);
    assign free_words = 32'(DEPTH) - 32'(max_occ);
    assign need_words = (32'(bus.samp_max) + 32'd1) * 32'(NGRP);
    assign admit      = launch && (free_words >= need_words) && (hdr_cnt != (HAW+1)'(HDR_DEPTH));
    assign drop       = launch && !admit;
    assign take       = (state == CAPTURE) && bus.gin_vld && !busy && !last_taken;

    // A trigger and a launch on the same cycle cancel. A trigger that finds the
    // queue full is lost; that loss is what pend_sat records.
    always_comb begin
        pend_nxt = pend;
        if (bus.trig && !launch) begin
            if (pend != 4'hF) pend_nxt = pend + 4'd1;
        end else if (launch && !bus.trig) begin
            pend_nxt = pend - 4'd1;
        end
    end

    assign hdr_word = {drop_flag, pend_sat, pend_nxt, 2'b00, trig_cnt};

    // Event FSM: trigger queue, admission/drop decision, sample acceptance and
    // the group-write sequencer that steps sel through the held sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            trig_cnt   <= '0;
            pend       <= '0;
            pend_sat   <= 1'b0;
            drop_flag  <= 1'b0;
            drop_cnt   <= '0;
            seq_err    <= 1'b0;
            samp_max_l <= '0;
            samp_cnt   <= '0;
            last_taken <= 1'b0;
            wr_act     <= 1'b0;
            sel        <= '0;
            hold       <= '0;
        end else begin
            if (bus.trig) trig_cnt <= trig_cnt + 24'd1;
            pend <= pend_nxt;
            if (bus.trig && !launch && (pend == 4'hF)) pend_sat <= 1'b1;
            else if (admit)                             pend_sat <= 1'b0;
            if (bus.gin_vld && busy) seq_err <= 1'b1;

            if (wr_act) begin
                if (last_grp) begin
                    wr_act <= 1'b0;
                    sel    <= '0;
                end else begin
                    sel <= sel + GW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (admit) begin
                        samp_max_l <= bus.samp_max;
                        samp_cnt   <= 7'd1;
                        last_taken <= (bus.samp_max == 7'd0);
                        hold       <= bus.gin;
                        wr_act     <= 1'b1;
                        sel        <= '0;
                        drop_flag  <= 1'b0;
                        state      <= CAPTURE;
                    end else if (drop) begin
                        drop_flag <= 1'b1;
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    end
                end
                CAPTURE: begin
                    if (take) begin
                        hold       <= bus.gin;
                        wr_act     <= 1'b1;
                        sel        <= '0;
                        samp_cnt   <= samp_cnt + 7'd1;
                        last_taken <= (samp_cnt == samp_max_l);
                    end
                    if (wr_act && last_grp && last_taken) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slice the current group out of the holding register, one word per channel.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
`ifdef PARITY_EN
            wr_word[c] = {^hold[(int'(sel) * NCH + c) * SW +: SW], hold[(int'(sel) * NCH + c) * SW +: SW]};
`else
            wr_word[c] = hold[(int'(sel) * NCH + c) * SW +: SW];
`endif
            rd_do[c] = bus.rd_ena[c] && (occ[c] != '0);
        end
    end

    // Data storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_act) begin
            for (int c = 0; c < NCH; c++) data_mem[c][wr_ptr] <= wr_word[c];
        end
    end

    // Per-channel read side; the write pointer is shared by all channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int c = 0; c < NCH; c++) begin
                rd_ptr[c] <= '0;
                occ[c]    <= '0;
                dout_r[c] <= '0;
`ifdef PARITY_EN
                bus.perr[c] <= 1'b0;
`endif
            end
        end else begin
            if (wr_act) wr_ptr <= wr_ptr + AW'(1);
            for (int c = 0; c < NCH; c++) begin
                if (rd_do[c]) begin
                    dout_r[c] <= data_mem[c][rd_ptr[c]][SW-1:0];
                    rd_ptr[c] <= rd_ptr[c] + AW'(1);
`ifdef PARITY_EN
                    bus.perr[c] <= ^data_mem[c][rd_ptr[c]];
`endif
                end
                if (wr_act && !rd_do[c])      occ[c] <= occ[c] + (AW+1)'(1);
                else if (!wr_act && rd_do[c]) occ[c] <= occ[c] - (AW+1)'(1);
            end
        end
    end

    always_comb begin
        dout_flat = '0;
        for (int c = 0; c < NCH; c++) dout_flat[c*SW +: SW] = dout_r[c];
    end

    assign hdr_rd = bus.hdr_rd_en && (hdr_cnt != '0);

    always_ff @(posedge clk) begin
        if (admit) hdr_mem[hdr_wp] <= hdr_word;
    end

    // Header FIFO pointers and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_wp    <= '0;
            hdr_rp    <= '0;
            hdr_cnt   <= '0;
            hdr_out_r <= '0;
        end else begin
            if (admit) hdr_wp <= hdr_wp + HAW'(1);
            if (hdr_rd) begin
                hdr_out_r <= hdr_mem[hdr_rp];
                hdr_rp    <= hdr_rp + HAW'(1);
            end
            if (admit && !hdr_rd)      hdr_cnt <= hdr_cnt + (HAW+1)'(1);
            else if (!admit && hdr_rd) hdr_cnt <= hdr_cnt - (HAW+1)'(1);
        end
    end

    assign bus.dout     = dout_flat;
    assign bus.hdr_out  = hdr_out_r;
    assign bus.rdy      = (hdr_cnt != '0);
    assign bus.drop_cnt = drop_cnt;
    assign bus.seq_err  = seq_err;
endmodule

// File: tb/tb_daq_event_buffer.sv
// ---------------------------------------------------------------------------
// tb_daq_event_buffer
//   Directed bench for daq_event_buffer (NCH=16, SW=12, NGRP=6, DEPTH=128).
//   Sample word for sample s, group g, channel c is seed ^ {s[3:0],g[3:0],c[3:0]},
//   so every word read back can be predicted from the event seed alone.
//   A table of single-event captures is run first, followed by hand-written
//   sequences for queued triggers, drops, pend saturation, sequencing errors
//   and reset mid-capture. Inputs change 1 ns after the rising edge and
//   outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_daq_event_buffer;
    localparam int NCH       = 16;
    localparam int SW        = 12;
    localparam int NGRP      = 6;
    localparam int DEPTH     = 128;
    localparam int HDR_DEPTH = 64;
    localparam int VW        = NCH * SW;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    daq_event_buffer_if #(.NCH(NCH), .SW(SW), .NGRP(NGRP)) bus ();

    daq_event_buffer #(
        .NCH(NCH), .SW(SW), .NGRP(NGRP), .DEPTH(DEPTH), .HDR_DEPTH(HDR_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [6:0]  samp_max;
        logic [11:0] seed;
        int          n_trig;
        logic [31:0] exp_hdr;
    } vec_t;

    vec_t vecs [3];

    function automatic logic [SW-1:0] pat(input logic [11:0] seed, input int s, input int g, input int c);
        logic [11:0] t;
        t = {4'(s), 4'(g), 4'(c)};
        return seed ^ t;
    endfunction

    function automatic logic [VW-1:0] exp_vec(input logic [11:0] seed, input int s, input int g);
        logic [VW-1:0] v;
        for (int c = 0; c < NCH; c++) v[c*SW +: SW] = pat(seed, s, g, c);
        return v;
    endfunction

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.gin       = '0;
        bus.gin_vld   = 1'b0;
        bus.trig      = 1'b0;
        bus.samp_max  = '0;
        bus.rd_ena    = '0;
        bus.hdr_rd_en = 1'b0;
        cycle(3);
        rst_n = 1'b1;
        cycle(1);
    endtask

    task automatic pulse_trig();
        bus.trig = 1'b1;
        cycle(1);
        bus.trig = 1'b0;
    endtask

    task automatic send_sample(input logic [11:0] seed, input int s, input logic with_trig, input int gap);
        for (int g = 0; g < NGRP; g++) begin
            for (int c = 0; c < NCH; c++) bus.gin[(g*NCH + c)*SW +: SW] = pat(seed, s, g, c);
        end
        bus.gin_vld = 1'b1;
        bus.trig    = with_trig;
        cycle(1);
        bus.gin_vld = 1'b0;
        bus.trig    = 1'b0;
        if (gap > 1) cycle(gap - 1);
    endtask

    task automatic send_event(input logic [6:0] samp_max, input logic [11:0] seed, input logic first_trig);
        bus.samp_max = samp_max;
        for (int s = 0; s <= int'(samp_max); s++) send_sample(seed, s, first_trig && (s == 0), 8);
    endtask

    task automatic read_words(input string name, input logic [11:0] seed, input int nsamp);
        bus.rd_ena = '1;
        for (int s = 0; s < nsamp; s++) begin
            for (int g = 0; g < NGRP; g++) begin
                cycle(1);
                checkOutput(name, 256'(bus.dout), 256'(exp_vec(seed, s, g)));
            end
        end
        bus.rd_ena = '0;
    endtask

    task automatic read_hdr(input string name, input logic [31:0] exp);
        bus.hdr_rd_en = 1'b1;
        cycle(1);
        bus.hdr_rd_en = 1'b0;
        checkOutput(name, 256'(bus.hdr_out), 256'(exp));
    endtask

    // One table row: fresh reset, n_trig triggers, one full event window.
    task automatic applyStimulus(input vec_t v);
        do_reset();
        bus.samp_max = v.samp_max;
        repeat (v.n_trig) pulse_trig();
        cycle(2);
        send_event(v.samp_max, v.seed, 1'b0);
    endtask

    initial begin
        vecs[0] = '{samp_max: 7'd7, seed: 12'h000, n_trig: 1, exp_hdr: 32'h0000_0001};
        vecs[1] = '{samp_max: 7'd0, seed: 12'hA5A, n_trig: 2, exp_hdr: 32'h0400_0002};
        vecs[2] = '{samp_max: 7'd3, seed: 12'hFFF, n_trig: 3, exp_hdr: 32'h0800_0003};

        do_reset();
        checkOutput("reset_rdy",      256'(bus.rdy),      256'(0));
        checkOutput("reset_dout",     256'(bus.dout),     256'(0));
        checkOutput("reset_hdr_out",  256'(bus.hdr_out),  256'(0));
        checkOutput("reset_drop_cnt", 256'(bus.drop_cnt), 256'(0));
        checkOutput("reset_seq_err",  256'(bus.seq_err),  256'(0));

        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i]);
            checkOutput("tbl_rdy_set", 256'(bus.rdy), 256'(1));
            read_hdr("tbl_hdr", vecs[i].exp_hdr);
            checkOutput("tbl_rdy_clr", 256'(bus.rdy), 256'(0));
            read_words("tbl_data", vecs[i].seed, int'(vecs[i].samp_max) + 1);
            bus.rd_ena = '1;
            cycle(1);
            bus.rd_ena = '0;
            checkOutput("tbl_empty_hold", 256'(bus.dout),
                        256'(exp_vec(vecs[i].seed, int'(vecs[i].samp_max), NGRP - 1)));
            checkOutput("tbl_drop_cnt", 256'(bus.drop_cnt), 256'(0));
            checkOutput("tbl_seq_err",  256'(bus.seq_err),  256'(0));
        end

        // Second trigger on the launching sample: two back-to-back windows.
        do_reset();
        bus.samp_max = 7'd7;
        pulse_trig();
        cycle(2);
        send_event(7'd7, 12'h000, 1'b1);
        send_event(7'd7, 12'h0F0, 1'b0);
        read_hdr("b2b_hdr1", 32'h0400_0001);
        read_hdr("b2b_hdr2", 32'h0000_0002);
        read_words("b2b_data1", 12'h000, 8);
        read_words("b2b_data2", 12'h0F0, 8);

        // 66-word event leaves 62 free: a second 66-word event is dropped,
        // a following 48-word event is admitted and carries drop_flag.
        do_reset();
        bus.samp_max = 7'd10;
        pulse_trig();
        cycle(2);
        send_event(7'd10, 12'h111, 1'b0);
        pulse_trig();
        send_sample(12'h999, 0, 1'b0, 8);
        checkOutput("drop_cnt_1", 256'(bus.drop_cnt), 256'(1));
        pulse_trig();
        send_event(7'd7, 12'h222, 1'b0);
        checkOutput("drop_cnt_hold", 256'(bus.drop_cnt), 256'(1));
        read_hdr("drop_hdr1", 32'h0000_0001);
        read_hdr("drop_hdr2", 32'h8000_0003);
        read_words("drop_data1", 12'h111, 11);
        read_words("drop_data2", 12'h222, 8);

        // 18 triggers saturate the queue at 15.
        do_reset();
        repeat (18) pulse_trig();
        send_event(7'd0, 12'h333, 1'b0);
        read_hdr("sat_hdr", 32'h7800_0012);
        read_words("sat_data", 12'h333, 1);

        // Samples 3 cycles apart: the second one is ignored and flagged.
        do_reset();
        bus.samp_max = 7'd1;
        pulse_trig();
        cycle(2);
        send_sample(12'h444, 0, 1'b0, 3);
        checkOutput("seq_err_clear", 256'(bus.seq_err), 256'(0));
        send_sample(12'h999, 9, 1'b0, 8);
        send_sample(12'h444, 1, 1'b0, 8);
        checkOutput("seq_err_set", 256'(bus.seq_err), 256'(1));
        read_hdr("seq_hdr", 32'h0000_0001);
        read_words("seq_data", 12'h444, 2);

        // Reset in the middle of a capture discards everything.
        do_reset();
        bus.samp_max = 7'd7;
        pulse_trig();
        cycle(2);
        send_sample(12'h555, 0, 1'b0, 8);
        send_sample(12'h555, 1, 1'b0, 8);
        send_sample(12'h555, 2, 1'b0, 3);
        rst_n = 1'b0;
        cycle(2);
        rst_n = 1'b1;
        cycle(1);
        checkOutput("abort_rdy",  256'(bus.rdy),  256'(0));
        checkOutput("abort_dout", 256'(bus.dout), 256'(0));
        bus.rd_ena    = '1;
        bus.hdr_rd_en = 1'b1;
        cycle(1);
        bus.rd_ena    = '0;
        bus.hdr_rd_en = 1'b0;
        checkOutput("abort_empty_dout", 256'(bus.dout),    256'(0));
        checkOutput("abort_empty_hdr",  256'(bus.hdr_out), 256'(0));
        pulse_trig();
        send_event(7'd0, 12'h666, 1'b0);
        read_hdr("abort_hdr", 32'h0000_0001);
        read_words("abort_data", 12'h666, 1);

`ifdef PARITY_EN
        do_reset();
        pulse_trig();
        cycle(2);
        send_event(7'd0, 12'h0A0, 1'b0);
        dut.data_mem[3][0] = dut.data_mem[3][0] ^ 13'h001;
        bus.rd_ena = '1;
        cycle(1);
        checkOutput("perr_flip", 256'(bus.perr), 256'(16'h0008));
        cycle(1);
        bus.rd_ena = '0;
        checkOutput("perr_clean", 256'(bus.perr), 256'(16'h0000));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
